// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: per-producer result channels in, register-file write port
// and hazard-unit busy mask out.
interface wb_arbiter_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned XLEN   = 32
);
    logic [NUM_CH-1:0]      ch_valid_w;
    logic [NUM_CH-1:0]      ch_ready_w;
    logic [NUM_CH*5-1:0]    ch_rd_w;
    logic [NUM_CH*XLEN-1:0] ch_data_w;
    logic                   reg_write_w;
    logic [4:0]             rd_w;
    logic [XLEN-1:0]        result_w;
    logic [NUM_CH-1:0]      grant_w;
    logic [31:0]            rd_busy_w;

    // Producer/pipeline side
    modport master (
        output ch_valid_w, ch_rd_w, ch_data_w,
        input  ch_ready_w, reg_write_w, rd_w, result_w, grant_w, rd_busy_w
    );

    // Arbiter side
    modport slave (
        input  ch_valid_w, ch_rd_w, ch_data_w,
        output ch_ready_w, reg_write_w, rd_w, result_w, grant_w, rd_busy_w
    );
endinterface

// File: rtl/wb_arbiter.sv
// RV32i writeback stage: NUM_CH producer FIFOs merged onto the single register-file
// write port by a round-robin arbiter, plus a busy-register mask for the hazard unit.
// Optional macro WB_BYPASS_EN: an empty channel may be granted straight from its
// inputs for zero-cycle latency.
module wb_arbiter #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned RW  = $clog2(NUM_CH);
    localparam int unsigned RDW = 5;

    logic [PW-1:0]   rd_ptr   [NUM_CH];
    logic [PW-1:0]   wr_ptr   [NUM_CH];
    logic [CW-1:0]   count    [NUM_CH];
    logic [RDW-1:0]  mem_rd   [NUM_CH][DEPTH];
    logic [XLEN-1:0] mem_data [NUM_CH][DEPTH];

    logic [RW-1:0]     rr_ptr;
    logic [RW-1:0]     gnt_idx;
    logic              gnt_any;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] ready;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] byp;
    logic [NUM_CH-1:0] enq;
    logic [NUM_CH-1:0] deq;
    logic [RDW-1:0]    sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [31:0]       busy;

    // Pointer increment with explicit wrap so DEPTH=1 also works
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Per-channel status and request
    always_comb begin
        ready = '0;
        empty = '0;
        req   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ready[i] = (count[i] != CW'(DEPTH));
            empty[i] = (count[i] == '0);
`ifdef WB_BYPASS_EN
            req[i]   = !empty[i] || bus.ch_valid_w[i];
`else
            req[i]   = !empty[i];
`endif
        end
    end

    // Round-robin pick: first requester at or after rr_ptr
    always_comb begin
        int unsigned c;
        c       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        grant   = '0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            c = (32'(rr_ptr) + off) % NUM_CH;
            if (!gnt_any && req[RW'(c)]) begin
                gnt_any = 1'b1;
                gnt_idx = RW'(c);
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    // Bypass selection, enqueue and dequeue strobes
    always_comb begin
        byp = '0;
`ifdef WB_BYPASS_EN
        if (gnt_any && empty[gnt_idx]) begin
            byp[gnt_idx] = 1'b1;
        end
`endif
        enq = bus.ch_valid_w & ready & ~byp;
        deq = grant & ~empty;
    end

    // Write-port data from the granted head (or granted inputs when bypassing)
    always_comb begin
        sel_rd   = mem_rd[gnt_idx][rd_ptr[gnt_idx]];
        sel_data = mem_data[gnt_idx][rd_ptr[gnt_idx]];
`ifdef WB_BYPASS_EN
        if (byp[gnt_idx]) begin
            sel_rd   = bus.ch_rd_w[32'(gnt_idx)*RDW +: RDW];
            sel_data = bus.ch_data_w[32'(gnt_idx)*XLEN +: XLEN];
        end
`endif
        if (!gnt_any) begin
            sel_rd   = '0;
            sel_data = '0;
        end
    end

    // Busy mask over every occupied FIFO slot; x0 never reported
    always_comb begin
        int unsigned slot;
        slot = 0;
        busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (CW'(k) < count[i]) begin
                    slot = (32'(rd_ptr[i]) + k) % DEPTH;
                    busy[mem_rd[i][PW'(slot)]] = 1'b1;
                end
            end
        end
        busy[0] = 1'b0;
    end

    assign bus.ch_ready_w  = ready;
    assign bus.grant_w     = grant;
    assign bus.rd_w        = sel_rd;
    assign bus.result_w    = sel_data;
    assign bus.reg_write_w = gnt_any && (sel_rd != '0);
    assign bus.rd_busy_w   = busy;

    // Control state: FIFO pointers/counts and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            if (gnt_any) begin
                rr_ptr <= (32'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + RW'(1);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (enq[i]) begin
                    wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                end
                if (deq[i]) begin
                    rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                end
                case ({enq[i], deq[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (enq[i]) begin
                mem_rd[i][wr_ptr[i]]   <= bus.ch_rd_w[i*RDW +: RDW];
                mem_data[i][wr_ptr[i]] <= bus.ch_data_w[i*XLEN +: XLEN];
            end
        end
    end
endmodule
